// File: rtl/vga_sprite_pkg.sv
// Shared constants for the multi-sprite overlay: register map, ctrl layout,
// palette table and reset defaults.
package vga_sprite_pkg;

   typedef logic [11:0] rgb12_t;

   localparam logic [1:0] REG_X0     = 2'd0;
   localparam logic [1:0] REG_Y0     = 2'd1;
   localparam logic [1:0] REG_CTRL   = 2'd2;
   localparam logic [1:0] GLB_BYPASS = 2'd0;
   localparam logic [1:0] GLB_COLL   = 2'd1;
   localparam logic [1:0] GLB_PERIOD = 2'd2;

   localparam int CTRL_W     = 6;
   localparam int CTRL_EN    = 0;
   localparam int CTRL_PAL   = 1;
   localparam int CTRL_AUTO  = 3;
   localparam int CTRL_FRAME = 4;

   localparam logic [10:0]       POS_RST    = '0;
   localparam logic [CTRL_W-1:0] CTRL_RST   = '0;
   localparam logic [7:0]        PERIOD_RST = 8'd8;

   // Row = palette select, column = pixel index - 1 (index 0 is transparent).
   localparam rgb12_t PALETTE [4][3] = '{
      '{12'hF00, 12'h0F0, 12'h00F},
      '{12'hFF0, 12'h0FF, 12'hF0F},
      '{12'h888, 12'h444, 12'hFFF},
      '{12'hF80, 12'h08F, 12'h000}
   };

   function automatic rgb12_t palette_lookup(input logic [1:0] sel, input logic [1:0] idx);
      rgb12_t c;
      c = '0;
      case (idx)
         2'd1:    c = PALETTE[sel][0];
         2'd2:    c = PALETTE[sel][1];
         2'd3:    c = PALETTE[sel][2];
         default: c = '0;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/vga_sprite_multi_core_lane.sv
// One sprite: pixel RAM, window hit test, palette lookup and the first
// pipeline register of the overlay path.
module sprite_lane
   import vga_sprite_pkg::*;
#(
   parameter int CD         = 12,
   parameter int SPRITE_DIM = 16,
   parameter int FW         = 2,
   localparam int DW        = $clog2(SPRITE_DIM),
   localparam int AW        = FW + 2 * DW
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic [10:0]   x_i,
   input  logic [10:0]   y_i,
   input  logic [10:0]   x0_i,
   input  logic [10:0]   y0_i,
   input  logic          en_i,
   input  logic [1:0]    pal_i,
   input  logic [FW-1:0] frame_i,
   input  logic          we_i,
   input  logic [AW-1:0] waddr_i,
   input  logic [1:0]    wdata_i,
   output logic          opaque_o,
   output logic [CD-1:0] colour_o
);

   logic [1:0]    ram [2**AW];
   logic [11:0]   x_ext, y_ext, x0_ext, y0_ext;
   logic          in_x, in_y;
   logic [DW-1:0] dx, dy;
   logic [1:0]    pix_idx;
   logic          opaque_d, opaque_q;
   logic [CD-1:0] colour_d, colour_q;

   // NOTE: the pixel RAM has no reset; sprites come out of reset disabled so
   // stale contents never reach the screen, and a reset would block RAM mapping.
   always_ff @(posedge clk) begin
      if (we_i) ram[waddr_i] <= wdata_i;
   end

   // 12-bit compare keeps x0+SPRITE_DIM from wrapping past 2047.
   assign x_ext  = {1'b0, x_i};
   assign y_ext  = {1'b0, y_i};
   assign x0_ext = {1'b0, x0_i};
   assign y0_ext = {1'b0, y0_i};
   assign in_x   = (x_ext >= x0_ext) && (x_ext < x0_ext + 12'(SPRITE_DIM));
   assign in_y   = (y_ext >= y0_ext) && (y_ext < y0_ext + 12'(SPRITE_DIM));
   assign dx     = x_i[DW-1:0] - x0_i[DW-1:0];
   assign dy     = y_i[DW-1:0] - y0_i[DW-1:0];

   assign pix_idx  = ram[{frame_i, dy, dx}];
   assign opaque_d = en_i && in_x && in_y && (pix_idx != 2'b00);
   assign colour_d = CD'(palette_lookup(pal_i, pix_idx));

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of process ordering.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         opaque_q <= 1'b0;
         colour_q <= '0;
      end else begin
         opaque_q <= opaque_d;
         colour_q <= colour_d;
      end
   end

   assign opaque_o = opaque_q;
   assign colour_o = colour_q;

endmodule

// File: rtl/vga_sprite_multi_core.sv
// Multi-sprite overlay on a VGA pixel stream: register file, animation timer,
// priority/collision resolve and the output blend register.
module vga_sprite_multi_core
   import vga_sprite_pkg::*;
#(
   parameter int CD          = 12,
   parameter int NUM_SPRITES = 4,
   parameter int SPRITE_DIM  = 16,
   parameter int NUM_FRAMES  = 4,
   parameter logic [CD-1:0] KEY_COLOR = '0
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic [10:0]   x,
   input  logic [10:0]   y,
   input  logic          cs,
   input  logic          write,
   input  logic          read,
   input  logic [13:0]   addr,
   input  logic [31:0]   wr_data,
   output logic [31:0]   rd_data,
   input  logic [CD-1:0] si_rgb,
   output logic [CD-1:0] so_rgb
);

   localparam int DW = $clog2(SPRITE_DIM);
   localparam int FW = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1;
   localparam int AW = FW + 2 * DW;

   logic [10:0]       x0_q   [NUM_SPRITES];
   logic [10:0]       y0_q   [NUM_SPRITES];
   logic [CTRL_W-1:0] ctrl_q [NUM_SPRITES];
   logic              bypass_q;
   logic [7:0]        period_q, tick_cnt_q, tick_cnt_d;
   logic [FW-1:0]     frame_q, frame_d;
   logic              origin_q, tick;
   logic [NUM_SPRITES-1:0] coll_q, coll_d, lane_opaque;
   logic [CD-1:0]     lane_colour [NUM_SPRITES];
   logic [CD-1:0]     si_q, so_rgb_q, so_d, win_colour;
   logic              win_opaque, multi_hit, reg_we, glb_we, coll_clr;
   logic [2:0]        n_opaque;
   logic              unused_bus;

   assign reg_we   = cs && write && addr[13] && !addr[6];
   assign glb_we   = cs && write && addr[13] && addr[6];
   assign coll_clr = glb_we && (addr[1:0] == GLB_COLL);
   assign unused_bus = ^{addr, wr_data};

   for (genvar g = 0; g < NUM_SPRITES; g++) begin : g_lane
      logic [FW-1:0] lane_frame;
      assign lane_frame = ctrl_q[g][CTRL_AUTO] ? frame_q : FW'(ctrl_q[g][CTRL_FRAME +: 2]);
      sprite_lane #(.CD(CD), .SPRITE_DIM(SPRITE_DIM), .FW(FW)) u_lane (
         .clk      (clk),
         .reset_n  (reset_n),
         .x_i      (x),
         .y_i      (y),
         .x0_i     (x0_q[g]),
         .y0_i     (y0_q[g]),
         .en_i     (ctrl_q[g][CTRL_EN]),
         .pal_i    (ctrl_q[g][CTRL_PAL +: 2]),
         .frame_i  (lane_frame),
         .we_i     (cs && write && !addr[13] && (addr[12:11] == 2'(g))),
         .waddr_i  (addr[AW-1:0]),
         .wdata_i  (wr_data[1:0]),
         .opaque_o (lane_opaque[g]),
         .colour_o (lane_colour[g])
      );
   end

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      win_opaque = 1'b0;
      win_colour = '0;
      n_opaque   = '0;
      for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
         n_opaque = n_opaque + {2'b00, lane_opaque[i]};
         if (lane_opaque[i]) begin
            win_opaque = 1'b1;
            win_colour = lane_colour[i];
         end
      end
      multi_hit = (n_opaque >= 3'd2);
      so_d = (bypass_q || !win_opaque || win_colour == KEY_COLOR) ? si_q : win_colour;
      // A same-cycle set wins over a software clear.
      coll_d = (coll_q & ~(coll_clr ? wr_data[NUM_SPRITES-1:0] : '0))
             | (multi_hit ? lane_opaque : '0);
   end

   assign tick = (x == 11'd0) && (y == 11'd0) && !origin_q;

   always_comb begin
      tick_cnt_d = tick_cnt_q;
      frame_d    = frame_q;
      if (tick && period_q != 8'd0) begin
         if ({1'b0, tick_cnt_q} + 9'd1 >= {1'b0, period_q}) begin
            tick_cnt_d = '0;
            frame_d    = (frame_q == FW'(NUM_FRAMES - 1)) ? '0 : frame_q + 1'b1;
         end else begin
            tick_cnt_d = tick_cnt_q + 8'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < NUM_SPRITES; i++) begin
            x0_q[i]   <= POS_RST;
            y0_q[i]   <= POS_RST;
            ctrl_q[i] <= CTRL_RST;
         end
         bypass_q   <= 1'b0;
         period_q   <= PERIOD_RST;
         coll_q     <= '0;
         tick_cnt_q <= '0;
         frame_q    <= '0;
         origin_q   <= 1'b0;
         si_q       <= '0;
         so_rgb_q   <= '0;
      end else begin
         for (int i = 0; i < NUM_SPRITES; i++) begin
            if (reg_we && addr[5:2] == 4'(i)) begin
               case (addr[1:0])
                  REG_X0:   x0_q[i]   <= wr_data[10:0];
                  REG_Y0:   y0_q[i]   <= wr_data[10:0];
                  REG_CTRL: ctrl_q[i] <= wr_data[CTRL_W-1:0];
                  default:  ;
               endcase
            end
         end
         if (glb_we && addr[1:0] == GLB_BYPASS) bypass_q <= wr_data[0];
         if (glb_we && addr[1:0] == GLB_PERIOD) period_q <= wr_data[7:0];
         coll_q     <= coll_d;
         tick_cnt_q <= tick_cnt_d;
         frame_q    <= frame_d;
         origin_q   <= (x == 11'd0) && (y == 11'd0);
         si_q       <= si_rgb;
         so_rgb_q   <= so_d;
      end
   end

   always_comb begin
      rd_data = '0;
      if (cs && read && addr[13]) begin
         if (!addr[6]) begin
            for (int i = 0; i < NUM_SPRITES; i++) begin
               if (addr[5:2] == 4'(i)) begin
                  case (addr[1:0])
                     REG_X0:   rd_data = {21'd0, x0_q[i]};
                     REG_Y0:   rd_data = {21'd0, y0_q[i]};
                     REG_CTRL: rd_data = 32'(ctrl_q[i]);
                     default:  rd_data = '0;
                  endcase
               end
            end
         end else begin
            case (addr[1:0])
               GLB_BYPASS: rd_data = {31'd0, bypass_q};
               GLB_COLL:   rd_data = 32'(coll_q);
               GLB_PERIOD: rd_data = {24'd0, period_q};
               default:    rd_data = '0;
            endcase
         end
      end
   end

   assign so_rgb = so_rgb_q;

endmodule

// File: tb/tb_vga_sprite_multi_core.sv
// Directed bench: pixel expectations go into a scoreboard queue and a
// monitor compares so_rgb two clocks later; register reads are checked inline.
module tb_vga_sprite_multi_core;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [10:0] x, y;
   logic        cs, write, read;
   logic [13:0] addr;
   logic [31:0] wr_data, rd_data;
   logic [11:0] si_rgb, so_rgb;

   typedef struct {
      logic [10:0] px;
      logic [10:0] py;
      logic [11:0] exp;
   } exp_t;

   exp_t sb_q[$];
   logic stim_vld;
   logic [1:0] vld_pipe;
   int n_checks = 0;
   int n_pass   = 0;

   vga_sprite_multi_core dut (
      .clk     (clk),
      .reset_n (reset_n),
      .x       (x),
      .y       (y),
      .cs      (cs),
      .write   (write),
      .read    (read),
      .addr    (addr),
      .wr_data (wr_data),
      .rd_data (rd_data),
      .si_rgb  (si_rgb),
      .so_rgb  (so_rgb)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
   endtask

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) vld_pipe <= 2'b00;
      else          vld_pipe <= {vld_pipe[0], stim_vld};
   end

   always @(negedge clk) begin : monitor
      exp_t e;
      if (vld_pipe[1]) begin
         if (sb_q.size() == 0) begin
            n_checks++;
            $display("FAIL sb_underflow: output with no expectation queued");
         end else begin
            e = sb_q.pop_front();
            check($sformatf("pix(%0d,%0d)", e.px, e.py), {20'd0, so_rgb}, {20'd0, e.exp});
         end
      end
   end

   function automatic logic [13:0] ram_a(input int s, input int w);
      return {1'b0, 2'(s), 1'b0, 10'(w)};
   endfunction
   function automatic logic [13:0] reg_a(input int s, input int r);
      return {1'b1, 6'd0, 1'b0, 4'(s), 2'(r)};
   endfunction
   function automatic logic [13:0] glb_a(input int r);
      return {1'b1, 6'd0, 1'b1, 4'd0, 2'(r)};
   endfunction

   task automatic pix(input int px, input int py, input logic [11:0] si, input logic [11:0] exp);
      exp_t e;
      @(negedge clk);
      x = 11'(px); y = 11'(py); si_rgb = si; stim_vld = 1'b1;
      e.px = 11'(px); e.py = 11'(py); e.exp = exp;
      sb_q.push_back(e);
   endtask

   task automatic drain();
      @(negedge clk);
      stim_vld = 1'b0; x = 11'd1000; y = 11'd1000;
      repeat (3) @(negedge clk);
   endtask

   task automatic bus_wr(input logic [13:0] a, input logic [31:0] d);
      @(negedge clk);
      stim_vld = 1'b0; cs = 1'b1; write = 1'b1; addr = a; wr_data = d;
      @(negedge clk);
      cs = 1'b0; write = 1'b0;
   endtask

   task automatic bus_rd(input string name, input logic [13:0] a, input logic [31:0] exp);
      @(negedge clk);
      stim_vld = 1'b0; cs = 1'b1; read = 1'b1; addr = a;
      #1 check(name, rd_data, exp);
      cs = 1'b0; read = 1'b0;
   endtask

   // Sprite 2 frames hold index 1,2,3,0 at offset (0,0); palette 1.
   function automatic logic [11:0] anim_col(input int f, input logic [11:0] si);
      case (f)
         0:       return 12'hFF0;
         1:       return 12'h0FF;
         2:       return 12'hF0F;
         default: return si;
      endcase
   endfunction

   initial begin
      int ticks, fidx;
      reset_n = 1'b0; x = 11'd1000; y = 11'd1000; cs = 1'b0; write = 1'b0; read = 1'b0;
      addr = '0; wr_data = '0; si_rgb = '0; stim_vld = 1'b0;
      repeat (3) @(negedge clk);
      check("so_rgb_in_reset", {20'd0, so_rgb}, 32'd0);
      reset_n = 1'b1;

      bus_rd("period_rst", glb_a(2), 32'd8);
      bus_rd("coll_rst",   glb_a(1), 32'd0);
      bus_rd("bypass_rst", glb_a(0), 32'd0);
      bus_rd("ctrl0_rst",  reg_a(0, 2), 32'd0);
      pix(100, 50, 12'h123, 12'h123);
      pix(5, 5, 12'h456, 12'h456);
      drain();

      // Sprite 0 at (100,50), palette 0, RAM all index 1 -> F00.
      for (int w = 0; w < 256; w++) bus_wr(ram_a(0, w), 32'd1);
      bus_wr(reg_a(0, 0), 32'd100);
      bus_wr(reg_a(0, 1), 32'd50);
      bus_wr(reg_a(0, 2), 32'd1);
      bus_rd("x0_rb", reg_a(0, 0), 32'd100);
      bus_rd("ctrl0_rb", reg_a(0, 2), 32'd1);
      pix(99, 50, 12'h111, 12'h111);
      pix(100, 50, 12'h222, 12'hF00);
      pix(115, 50, 12'h333, 12'hF00);
      pix(116, 50, 12'h444, 12'h444);
      pix(100, 49, 12'h555, 12'h555);
      pix(100, 65, 12'h666, 12'hF00);
      pix(100, 66, 12'h777, 12'h777);
      pix(107, 58, 12'h888, 12'hF00);
      drain();

      // Overlap at (200,200): sprite 0 wins, both collision bits set.
      bus_wr(ram_a(1, 0), 32'd2);
      bus_wr(ram_a(1, 1), 32'd2);
      bus_wr(reg_a(1, 0), 32'd200);
      bus_wr(reg_a(1, 1), 32'd200);
      bus_wr(reg_a(1, 2), 32'd5);
      bus_wr(reg_a(0, 0), 32'd200);
      bus_wr(reg_a(0, 1), 32'd200);
      pix(200, 200, 12'h0A1, 12'hF00);
      pix(199, 200, 12'h0A2, 12'h0A2);
      pix(200, 199, 12'h0A3, 12'h0A3);
      drain();
      bus_rd("coll_set", glb_a(1), 32'd3);
      bus_wr(glb_a(1), 32'd1);
      bus_rd("coll_clr0", glb_a(1), 32'd2);
      bus_wr(reg_a(0, 2), 32'd0);
      pix(201, 200, 12'h0A4, 12'h444);
      drain();
      bus_rd("coll_sticky", glb_a(1), 32'd2);

      // Palette 3 index 3 is 000, equal to the key colour -> upstream shows.
      bus_wr(ram_a(1, 2), 32'd3);
      bus_wr(reg_a(1, 2), 32'd7);
      pix(200, 200, 12'h0B1, 12'h08F);
      pix(202, 200, 12'h0B2, 12'h0B2);
      pix(201, 200, 12'h0B3, 12'h08F);
      drain();

      // Bypass.
      bus_wr(reg_a(1, 2), 32'd0);
      bus_wr(reg_a(0, 0), 32'd100);
      bus_wr(reg_a(0, 1), 32'd50);
      bus_wr(reg_a(0, 2), 32'd1);
      bus_wr(glb_a(0), 32'd1);
      bus_rd("bypass_rb", glb_a(0), 32'd1);
      pix(100, 50, 12'h0C1, 12'h0C1);
      pix(105, 55, 12'h0C2, 12'h0C2);
      drain();
      bus_wr(glb_a(0), 32'd0);
      pix(105, 55, 12'h0C3, 12'hF00);
      drain();

      // Right-edge sprite must not wrap to x 0..7.
      bus_wr(reg_a(0, 0), 32'd2040);
      pix(2039, 50, 12'h0D1, 12'h0D1);
      pix(2040, 50, 12'h0D2, 12'hF00);
      pix(2047, 50, 12'h0D3, 12'hF00);
      pix(0, 50, 12'h0D4, 12'h0D4);
      pix(7, 50, 12'h0D5, 12'h0D5);
      drain();

      // Animation: sprite 2 auto-animate, palette 1, period 2.
      bus_wr(reg_a(0, 2), 32'd0);
      bus_wr(ram_a(2, 0),   32'd1);
      bus_wr(ram_a(2, 256), 32'd2);
      bus_wr(ram_a(2, 512), 32'd3);
      bus_wr(ram_a(2, 768), 32'd0);
      bus_wr(reg_a(2, 0), 32'd300);
      bus_wr(reg_a(2, 1), 32'd300);
      bus_wr(reg_a(2, 2), 32'd11);
      bus_wr(glb_a(2), 32'd2);
      bus_rd("period_rb", glb_a(2), 32'd2);
      ticks = 0; fidx = 0;
      pix(300, 300, 12'h0E0, anim_col(fidx, 12'h0E0));
      for (int k = 0; k < 8; k++) begin
         // Two consecutive origin pixels make exactly one tick.
         pix(0, 0, 12'h100 + 12'(k), 12'h100 + 12'(k));
         pix(0, 0, 12'h200 + 12'(k), 12'h200 + 12'(k));
         ticks++;
         if (ticks == 2) begin
            ticks = 0;
            fidx = (fidx + 1) % 4;
         end
         pix(300, 300, 12'h300 + 12'(k), anim_col(fidx, 12'h300 + 12'(k)));
      end
      drain();

      // Period 0 freezes the frame index (currently 0).
      bus_wr(glb_a(2), 32'd0);
      for (int k = 0; k < 3; k++) begin
         pix(0, 0, 12'h400, 12'h400);
         pix(300, 300, 12'h401, 12'hFF0);
      end
      drain();

      // Manual frame 2 with auto off.
      bus_wr(reg_a(2, 2), 32'd35);
      pix(300, 300, 12'h500, 12'hF0F);
      drain();

      // Asynchronous reset mid-frame.
      bus_rd("coll_pre_rst", glb_a(1), 32'd2);
      @(negedge clk);
      x = 11'd300; y = 11'd300; si_rgb = 12'h600;
      repeat (3) @(negedge clk);
      check("so_pre_rst", {20'd0, so_rgb}, 32'h00000F0F);
      #2 reset_n = 1'b0;
      #1 check("so_async_rst", {20'd0, so_rgb}, 32'd0);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      bus_rd("coll_post_rst",   glb_a(1), 32'd0);
      bus_rd("period_post_rst", glb_a(2), 32'd8);
      bus_rd("ctrl2_post_rst",  reg_a(2, 2), 32'd0);
      pix(300, 300, 12'h601, 12'h601);
      drain();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
